// File: rtl/div32.sv
// -----------------------------------------------------------------------------
// div32 -- iterative restoring divider (DIV / DIVU), one quotient bit per clock.
//
// A start request latches the operands and the signed/unsigned mode. The
// magnitudes are then divided over WIDTH RUN cycles. The final iteration writes
// the sign-corrected quotient and remainder into registered outputs. At the
// same time the FSM enters DONE, where oDone pulses for a single cycle.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset (priority over iStart)
//   iStart     in   1      start request, accepted in IDLE or DONE only
//   iSigned    in   1      1 = two's-complement divide, 0 = unsigned divide
//   iDividend  in   WIDTH  dividend, sampled with an accepted iStart
//   iDivisor   in   WIDTH  divisor, sampled with an accepted iStart
//   oQuotient  out  WIDTH  registered quotient (LO writeback)
//   oRemainder out  WIDTH  registered remainder (HI writeback)
//   oBusy      out  1      high on every RUN cycle
//   oDone      out  1      one-cycle pulse when results become valid
// -----------------------------------------------------------------------------
module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iStart,
    input  logic             iSigned,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic [WIDTH-1:0] oQuotient,
    output logic [WIDTH-1:0] oRemainder,
    output logic             oBusy,
    output logic             oDone
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negation, shared by operand magnitude and result fix-up.
    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_rem;        // partial remainder
    logic [WIDTH-1:0]   r_quo;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_dsr;        // divisor magnitude
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_q_final;
    logic [WIDTH-1:0]   w_r_final;

    // Operand magnitudes and one restoring-division step.
    always_comb begin
        w_a_neg    = iSigned & iDividend[WIDTH-1];
        w_b_neg    = iSigned & iDivisor[WIDTH-1];
        w_a_mag    = w_a_neg ? f_neg(iDividend) : iDividend;
        w_b_mag    = w_b_neg ? f_neg(iDivisor) : iDivisor;
        // Partial remainder is always below the divisor, so WIDTH+1 bits hold the shift.
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_dsr};
        w_qbit     = ~w_diff[WIDTH];
        w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_q_mag    = {r_quo[WIDTH-2:0], w_qbit};
        // A zero divisor yields an all-ones quotient in both modes. The remainder
        // needs no special case: it is the dividend magnitude with the dividend
        // sign restored, which equals the original dividend.
        if (r_div_zero) begin
            w_q_final = {WIDTH{1'b1}};
        end else begin
            w_q_final = r_neg_q ? f_neg(w_q_mag) : w_q_mag;
        end
        w_r_final  = r_neg_r ? f_neg(w_rem_next) : w_rem_next;
    end

    // Next-state logic and start acceptance.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_count == CW'(WIDTH - 1));
        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (iStart) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dsr       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div_zero  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else if (w_accept) begin
            r_count    <= '0;
            r_rem      <= '0;
            r_quo      <= w_a_mag;
            r_dsr      <= w_b_mag;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_div_zero <= (iDivisor == {WIDTH{1'b0}});
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_count <= r_count + CW'(1);
            r_rem   <= w_rem_next;
            r_quo   <= w_q_mag;
            if (w_last) begin
                r_quotient  <= w_q_final;
                r_remainder <= w_r_final;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
            end else begin
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
            end
        end else begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end
    end

    assign oQuotient  = r_quotient;
    assign oRemainder = r_remainder;
    assign oBusy      = r_busy;
    assign oDone      = r_done;

endmodule

// File: tb/tb_div32.sv
// -----------------------------------------------------------------------------
// tb_div32 -- table-driven self-checking bench for div32, plus hand-written
// sequences for start-while-running, back-to-back start and reset mid-RUN.
// -----------------------------------------------------------------------------
module tb_div32;

    logic        clk;
    logic        reset;
    logic        iStart;
    logic        iSigned;
    logic [31:0] iDividend;
    logic [31:0] iDivisor;
    logic [31:0] oQuotient;
    logic [31:0] oRemainder;
    logic        oBusy;
    logic        oDone;

    int n_cmp = 0;
    int n_err = 0;

    div32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .iStart     (iStart),
        .iSigned    (iSigned),
        .iDividend  (iDividend),
        .iDivisor   (iDivisor),
        .oQuotient  (oQuotient),
        .oRemainder (oRemainder),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge; applies iStart for the next edge and returns
    // at #1 after the accepting edge (cycle 1).
    task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        iStart    = 1'b1;
        iSigned   = sgn;
        iDividend = a;
        iDivisor  = b;
        @(posedge clk);
        #1;
        iStart = 1'b0;
    endtask

    // Samples from cycle first_cyc until oDone (bounded), counting busy cycles.
    // Records the quotient seen at cycle 16 to confirm outputs hold during RUN.
    task automatic wait_result(input int first_cyc, output int busy_n, output int done_at,
                               output logic [31:0] q_mid);
        int cyc;
        busy_n  = 0;
        done_at = 0;
        q_mid   = 32'h0;
        cyc     = first_cyc;
        while (cyc <= 40 && done_at == 0) begin
            if (cyc == 16) q_mid = oQuotient;
            if (oDone) begin
                done_at = cyc;
            end else begin
                if (oBusy) busy_n++;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
    endtask

    initial begin
        int          busy_n;
        int          done_at;
        int          saw_done;
        int          saw_busy;
        logic [31:0] q_mid;
        logic [31:0] prev_q;

        vecs[0]  = '{"u_100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
        vecs[1]  = '{"s_m7_2",     1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
        vecs[2]  = '{"s_7_m2",     1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
        vecs[3]  = '{"u_5_0",      1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5};
        vecs[4]  = '{"s_5_0",      1'b1, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5};
        vecs[5]  = '{"s_min_m1",   1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
        vecs[6]  = '{"u_min_m1",   1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000};
        vecs[7]  = '{"s_m7_m2",    1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF};
        vecs[8]  = '{"u_max_2",    1'b0, 32'hFFFFFFFF,  32'd2,         32'h7FFFFFFF,  32'd1};
        vecs[9]  = '{"s_m5_0",     1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB};
        vecs[10] = '{"u_hex",      1'b0, 32'h12345678,  32'h00001000,  32'h00012345,  32'h00000678};

        reset     = 1'b1;
        iStart    = 1'b0;
        iSigned   = 1'b0;
        iDividend = 32'h0;
        iDivisor  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q",    oQuotient,       32'h0);
        chk("rst_r",    oRemainder,      32'h0);
        chk("rst_busy", {31'b0, oBusy},  32'h0);
        chk("rst_done", {31'b0, oDone},  32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        prev_q = 32'h0;
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
            chk({vecs[i].name, "_busy1"}, {31'b0, oBusy}, 32'h1);
            wait_result(1, busy_n, done_at, q_mid);
            chk({vecs[i].name, "_busycnt"}, busy_n,   32'd32);
            chk({vecs[i].name, "_doneat"},  done_at,  32'd33);
            chk({vecs[i].name, "_qhold"},   q_mid,    prev_q);
            chk({vecs[i].name, "_q"},       oQuotient,  vecs[i].eq);
            chk({vecs[i].name, "_r"},       oRemainder, vecs[i].er);
            chk({vecs[i].name, "_busydn"},  {31'b0, oBusy}, 32'h0);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_pulse"},   {31'b0, oDone}, 32'h0);
            prev_q = vecs[i].eq;
        end

        // Start while running is ignored, even with operands changed afterwards.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        iStart    = 1'b1;
        iSigned   = 1'b1;
        iDividend = 32'd9;
        iDivisor  = 32'd3;
        @(posedge clk);
        #1;
        iStart = 1'b0;
        wait_result(6, busy_n, done_at, q_mid);
        chk("ign_busycnt", busy_n,     32'd27);
        chk("ign_doneat",  done_at,    32'd33);
        chk("ign_q",       oQuotient,  32'd14);
        chk("ign_r",       oRemainder, 32'd2);

        // New start in the DONE cycle goes straight back to RUN.
        start_op(1'b0, 32'd9, 32'd3);
        chk("b2b_busy1", {31'b0, oBusy}, 32'h1);
        chk("b2b_done0", {31'b0, oDone}, 32'h0);
        wait_result(1, busy_n, done_at, q_mid);
        chk("b2b_doneat", done_at,    32'd33);
        chk("b2b_qhold",  q_mid,      32'd14);
        chk("b2b_q",      oQuotient,  32'd3);
        chk("b2b_r",      oRemainder, 32'd0);
        @(posedge clk);
        #1;

        // Reset at RUN cycle 10 aborts the division and clears outputs.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_pre", {31'b0, oBusy}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", {31'b0, oBusy}, 32'h0);
        chk("abort_q",    oQuotient,      32'h0);
        chk("abort_r",    oRemainder,     32'h0);
        saw_done = 0;
        saw_busy = 0;
        for (int c = 0; c < 40; c++) begin
            if (oDone) saw_done++;
            if (oBusy) saw_busy++;
            @(posedge clk);
            #1;
        end
        chk("abort_nodone", saw_done, 32'd0);
        chk("abort_nobusy", saw_busy, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div32.md
DIV32 -- requirements
Module: div32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port iStart  input  1  request a new division; sampled on rising edge.
REQ-005 SHALL have port iSigned  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with iStart.
REQ-006 SHALL have port iDividend  input  WIDTH  dividend; sampled with iStart.
REQ-007 SHALL have port iDivisor  input  WIDTH  divisor; sampled with iStart.
REQ-008 SHALL have port oQuotient  output  WIDTH  registered quotient, destined for the LO writeback mux input.
REQ-009 SHALL have port oRemainder  output  WIDTH  registered remainder, destined for the HI writeback mux input.
REQ-010 SHALL have port oBusy  output  1  high while iterations are in progress.
REQ-011 SHALL have port oDone  output  1  one-cycle pulse marking the cycle results become valid.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 SHALL accept iStart only in IDLE or DONE: latch operands and iSigned, clear the iteration counter, and enter RUN.
REQ-014 SHALL ignore iStart while in RUN; latched operands SHALL NOT change.
REQ-015 SHALL ignore all input changes after acceptance until the next accepted start.
REQ-016 SHALL divide magnitudes with restoring division, one quotient bit per clock, for exactly WIDTH cycles in RUN.
REQ-017 SHALL take magnitudes as the two's-complement absolute value when iSigned=1 and the raw operand when iSigned=0.
REQ-018 SHALL assert oBusy on every RUN cycle: from the cycle after the start edge through WIDTH cycles.
REQ-019 SHALL, after the final iteration, enter DONE, update oQuotient/oRemainder, and assert oDone for exactly one cycle, with oBusy low.
REQ-020 SHALL produce oDone WIDTH+1 cycles after the accepting edge, i.e. 33 for WIDTH=32.
REQ-021 SHALL move from DONE to IDLE on the next cycle unless iStart is high; if iStart is high, SHALL go straight to RUN.
REQ-022 SHALL hold oQuotient/oRemainder from DONE until the next result is written; they SHALL NOT change during RUN.
REQ-023 SHALL, when iSigned=1, negate the quotient if the operand signs differ, and give the remainder the sign of the dividend.
REQ-024 SHALL satisfy dividend = quotient*divisor + remainder, with |remainder| < |divisor|, for a nonzero divisor.
REQ-025 SHALL handle divisor = 0 with normal latency, giving quotient all-ones and remainder = dividend regardless of iSigned.
REQ-026 SHALL handle the signed case most-negative / -1 with normal latency, giving quotient = most-negative (wrap) and remainder 0.
REQ-027 SHALL register outputs only; there SHALL be no combinational path from any input to any output.

Reset
REQ-028 SHALL, with reset high at a rising edge, enter IDLE and clear oQuotient, oRemainder, oBusy, oDone and the counter to 0.
REQ-029 SHALL give reset priority over iStart.
REQ-030 SHALL, when reset occurs mid-RUN, abort the operation: oBusy low next cycle, no oDone, and outputs cleared to 0.

Verification
REQ-031 SHALL be checked with iSigned=0, 100 / 7: oBusy high for 32 cycles, then oDone at cycle 33 with q=14, r=2.
REQ-032 SHALL be checked with iSigned=1: -7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; and 7 / -2 -> q=0xFFFFFFFD, r=1.
REQ-033 SHALL be checked with 5 / 0, both iSigned values -> q=0xFFFFFFFF, r=5, oDone at cycle 33.
REQ-034 SHALL be checked with 0x80000000 / 0xFFFFFFFF: iSigned=1 -> q=0x80000000, r=0; iSigned=0 -> q=0, r=0x80000000.
REQ-035 SHALL be checked as follows: start 100/7, pulse iStart with 9/3 at RUN cycle 5 -> ignored, result q=14, r=2; a new start in the DONE cycle -> oBusy next cycle, then q=3, r=0.
REQ-036 SHALL be checked with reset asserted at RUN cycle 10 -> oBusy=0 next cycle, outputs 0, no oDone pulse within 40 cycles.
